// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module  : reg_file_pkg
// Purpose : Shared constants and helpers for the scoreboarded register file.
//           Holds the default geometry and the ceil-log2 helper used to
//           validate that the index width matches the register count.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package reg_file_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;
    localparam int RF_ADDR_W   = 5;

    // Smallest w such that 2**w >= n (returns 0 for n <= 1).
    function automatic int rf_clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/reg_file_sb_rdport.sv
`default_nettype none
// ============================================================================
// Module  : reg_file_sb_rdport
// Purpose : One combinational read port of the register file. Selects the
//           stored word and pending bit for the requested index, applies the
//           write-to-read bypass (wr1 over wr0 over storage), forces zero for
//           the hardwired zero register and out-of-range indices, and derives
//           the busy flag (pending and not being written back this cycle).
// Ports   : i_active   - high when out of reset; low forces zero outputs
//           i_rdAddr   - read index
//           i_regsFlat - all stored registers, reg r at [r*DATA_W +: DATA_W]
//           i_pending  - scoreboard pending vector
//           i_wr0Ok/i_wr0Addr/i_wr0Data - validated write port 0
//           i_wr1Ok/i_wr1Addr/i_wr1Data - validated write port 1
//           o_rdData   - read data
//           o_rdBusy   - source still pending after this cycle's writebacks
// Revision: 1.0 - initial release
// ============================================================================
module reg_file_sb_rdport
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic                       i_active,
    input  logic [ADDR_W-1:0]          i_rdAddr,
    input  logic [NUM_REGS*DATA_W-1:0] i_regsFlat,
    input  logic [NUM_REGS-1:0]        i_pending,
    input  logic                       i_wr0Ok,
    input  logic [ADDR_W-1:0]          i_wr0Addr,
    input  logic [DATA_W-1:0]          i_wr0Data,
    input  logic                       i_wr1Ok,
    input  logic [ADDR_W-1:0]          i_wr1Addr,
    input  logic [DATA_W-1:0]          i_wr1Data,
    output logic [DATA_W-1:0]          o_rdData,
    output logic                       o_rdBusy
);

    logic              w_readable;
    logic [DATA_W-1:0] w_stored;
    logic              w_pend;
    logic              w_hit0;
    logic              w_hit1;

    always_comb begin
        // Index 0 is only special when the zero register is enabled.
        w_readable = (32'(i_rdAddr) < NUM_REGS) &&
                     !((ZERO_REG != 0) && (i_rdAddr == '0));

        // Constant-index mux: an out-of-range index matches nothing and
        // therefore yields zero data and no pending bit.
        w_stored = '0;
        w_pend   = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (ADDR_W'(r) == i_rdAddr) begin
                w_stored = i_regsFlat[r*DATA_W +: DATA_W];
                w_pend   = i_pending[r];
            end
        end

        // Write enables arrive already validated, so dropped writes
        // (zero register, out of range) can never bypass.
        w_hit0 = i_wr0Ok && (i_wr0Addr == i_rdAddr);
        w_hit1 = i_wr1Ok && (i_wr1Addr == i_rdAddr);

        o_rdData = '0;
        o_rdBusy = 1'b0;
        if (i_active && w_readable) begin
            if (w_hit1) begin
                o_rdData = i_wr1Data;
            end else if (w_hit0) begin
                o_rdData = i_wr0Data;
            end else begin
                o_rdData = w_stored;
            end
            // A writeback landing this cycle resolves the hazard immediately.
            o_rdBusy = w_pend && !(w_hit0 || w_hit1);
        end
    end

endmodule : reg_file_sb_rdport
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module  : reg_file_sb
// Purpose : Parametrised register file with NUM_RD combinational read ports,
//           two write ports (ALU and load writeback, wr1 wins on collision),
//           same-cycle write-to-read bypass, optional hardwired zero register
//           and a per-register pending scoreboard with a registered count.
// Ports   : clk      - rising-edge clock
//           rst_n    - asynchronous active-low reset
//           rd_addr  - NUM_RD packed read indices
//           rd_data  - NUM_RD packed read data
//           rd_busy  - per-port pending flag after this cycle's writebacks
//           wr0_*    - ALU writeback port
//           wr1_*    - load writeback port
//           iss_en/iss_addr - mark a destination pending
//           busy_cnt - registered count of pending registers
// Revision: 1.0 - initial release
// ============================================================================
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [ADDR_W:0]          busy_cnt
);

    // ------------------------------------------------------------------
    // Elaboration-time geometry checks
    // ------------------------------------------------------------------
    if (ADDR_W != rf_clog2(NUM_REGS)) begin : g_badAddrW
        $error("reg_file_sb: ADDR_W must equal clog2(NUM_REGS)");
    end
    if (NUM_REGS < 2) begin : g_badNumRegs
        $error("reg_file_sb: NUM_REGS must be at least 2");
    end
    if ((NUM_RD < 1) || (NUM_RD > 4)) begin : g_badNumRd
        $error("reg_file_sb: NUM_RD must be in 1..4");
    end

    // An index is a legal destination if it exists and is not the
    // hardwired zero register.
    function automatic logic f_writable(input logic [ADDR_W-1:0] a);
        return (32'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    logic [DATA_W-1:0]          r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]        r_pending;
    logic [ADDR_W:0]            r_busyCnt;

    logic                       w_wr0Ok;
    logic                       w_wr1Ok;
    logic                       w_issOk;
    logic [NUM_REGS-1:0]        w_pendNext;
    logic [ADDR_W:0]            w_pendCnt;
    logic [NUM_REGS*DATA_W-1:0] w_regsFlat;

    assign w_wr0Ok = wr0_en && f_writable(wr0_addr);
    assign w_wr1Ok = wr1_en && f_writable(wr1_addr);
    assign w_issOk = iss_en && f_writable(iss_addr);

    // ------------------------------------------------------------------
    // Storage: wr1 is checked first so it wins an address collision.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_wr1Ok && (wr1_addr == ADDR_W'(r))) begin
                    r_regs[r] <= wr1_data;
                end else if (w_wr0Ok && (wr0_addr == ADDR_W'(r))) begin
                    r_regs[r] <= wr0_data;
                end
            end
        end
    end

    always_comb begin
        w_regsFlat = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_regsFlat[r*DATA_W +: DATA_W] = r_regs[r];
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard next state. Issue beats a same-cycle writeback because
    // the newly issued producer supersedes the one being retired.
    // ------------------------------------------------------------------
    always_comb begin
        w_pendNext = r_pending;
        w_pendCnt  = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (w_issOk && (iss_addr == ADDR_W'(r))) begin
                w_pendNext[r] = 1'b1;
            end else if ((w_wr0Ok && (wr0_addr == ADDR_W'(r))) ||
                         (w_wr1Ok && (wr1_addr == ADDR_W'(r)))) begin
                w_pendNext[r] = 1'b0;
            end
            w_pendCnt = w_pendCnt + (ADDR_W+1)'(w_pendNext[r]);
        end
    end

    // The count is taken from the next-state vector so that it matches
    // the pending bits present right after the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_busyCnt <= '0;
        end else begin
            r_pending <= w_pendNext;
            r_busyCnt <= w_pendCnt;
        end
    end

    assign busy_cnt = r_busyCnt;

    // ------------------------------------------------------------------
    // Read ports. rst_n gates the outputs so reads are zero while the
    // bypass path would otherwise still see live write data in reset.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rdPort
        reg_file_sb_rdport #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rdPort (
            .i_active   (rst_n),
            .i_rdAddr   (rd_addr[k*ADDR_W +: ADDR_W]),
            .i_regsFlat (w_regsFlat),
            .i_pending  (r_pending),
            .i_wr0Ok    (w_wr0Ok),
            .i_wr0Addr  (wr0_addr),
            .i_wr0Data  (wr0_data),
            .i_wr1Ok    (w_wr1Ok),
            .i_wr1Addr  (wr1_addr),
            .i_wr1Data  (wr1_data),
            .o_rdData   (rd_data[k*DATA_W +: DATA_W]),
            .o_rdBusy   (rd_busy[k])
        );
    end

endmodule : reg_file_sb
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_file_sb
// Purpose : Directed self-checking bench for reg_file_sb with default
//           geometry (32 x 32-bit, two read ports, zero register enabled).
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;

    localparam int c_DW = 32;
    localparam int c_AW = 5;
    localparam int c_NR = 2;

    logic                 clk;
    logic                 rst_n;
    logic [c_NR*c_AW-1:0] rd_addr;
    logic [c_NR*c_DW-1:0] rd_data;
    logic [c_NR-1:0]      rd_busy;
    logic                 wr0_en;
    logic [c_AW-1:0]      wr0_addr;
    logic [c_DW-1:0]      wr0_data;
    logic                 wr1_en;
    logic [c_AW-1:0]      wr1_addr;
    logic [c_DW-1:0]      wr1_data;
    logic                 iss_en;
    logic [c_AW-1:0]      iss_addr;
    logic [c_AW:0]        busy_cnt;

    int nAsserts;
    int nFails;

    reg_file_sb #(
        .DATA_W   (c_DW),
        .NUM_REGS (32),
        .ADDR_W   (c_AW),
        .NUM_RD   (c_NR),
        .ZERO_REG (1)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .wr1_data (wr1_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy_cnt (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts = nAsserts + 1;
        if (obs !== exp) begin
            nFails = nFails + 1;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic setRd(input logic [c_AW-1:0] a0, input logic [c_AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic idle();
        wr0_en = 1'b0;
        wr1_en = 1'b0;
        iss_en = 1'b0;
    endtask

    initial begin
        nAsserts = 0;
        nFails   = 0;
        rst_n    = 1'b0;
        rd_addr  = '0;
        wr0_en   = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en   = 1'b0; wr1_addr = '0; wr1_data = '0;
        iss_en   = 1'b0; iss_addr = '0;

        // ---------------- reset then read ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt", 64'(busy_cnt), 64'd0);
        rst_n = 1'b1;
        cyc();
        wr0_en = 1'b1; wr0_addr = 5'd5;  wr0_data = 32'h0000_0055;
        wr1_en = 1'b1; wr1_addr = 5'd31; wr1_data = 32'h0000_3131;
        iss_en = 1'b1; iss_addr = 5'd5;
        cyc();
        idle();
        setRd(5'd5, 5'd31);
        #1;
        chk("pre_rst_rd0", 64'(rd_data[31:0]), 64'h55);
        chk("pre_rst_rd1", 64'(rd_data[63:32]), 64'h3131);
        chk("pre_rst_busy", 64'(rd_busy), 64'b01);
        chk("pre_rst_cnt", 64'(busy_cnt), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("in_rst_rd", 64'(rd_data), 64'd0);
        chk("in_rst_busy", 64'(rd_busy), 64'd0);
        chk("in_rst_cnt", 64'(busy_cnt), 64'd0);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("post_rst_rd", 64'(rd_data), 64'd0);
        chk("post_rst_busy", 64'(rd_busy), 64'd0);
        chk("post_rst_cnt", 64'(busy_cnt), 64'd0);
        cyc();

        // ---------------- write then read ----------------
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'hDEAD_BEEF;
        setRd(5'd3, 5'd0);
        #1;
        chk("wr_bypass", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
        cyc();
        idle();
        #1;
        chk("wr_stored", 64'(rd_data[31:0]), 64'hDEAD_BEEF);

        // ---------------- dual write same addr ----------------
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22;
        setRd(5'd3, 5'd7);
        #1;
        chk("dual_bypass", 64'(rd_data[63:32]), 64'h22);
        cyc();
        idle();
        #1;
        chk("dual_stored", 64'(rd_data[63:32]), 64'h22);

        // ---------------- dual write different addrs ----------------
        wr0_en = 1'b1; wr0_addr = 5'd1; wr0_data = 32'hA1;
        wr1_en = 1'b1; wr1_addr = 5'd2; wr1_data = 32'hB2;
        cyc();
        idle();
        setRd(5'd1, 5'd2);
        #1;
        chk("diff_rd0", 64'(rd_data[31:0]), 64'hA1);
        chk("diff_rd1", 64'(rd_data[63:32]), 64'hB2);

        // ---------------- zero register ----------------
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFF_FFFF;
        iss_en = 1'b1; iss_addr = 5'd0;
        setRd(5'd0, 5'd1);
        #1;
        chk("zero_bypass", 64'(rd_data[31:0]), 64'd0);
        chk("zero_busy", 64'(rd_busy), 64'd0);
        cyc();
        idle();
        #1;
        chk("zero_stored", 64'(rd_data[31:0]), 64'd0);
        chk("zero_busy2", 64'(rd_busy), 64'd0);
        chk("zero_cnt", 64'(busy_cnt), 64'd0);

        // ---------------- scoreboard ----------------
        iss_en = 1'b1; iss_addr = 5'd4;
        setRd(5'd4, 5'd9);
        #1;
        chk("iss_no_early", 64'(rd_busy), 64'b00);
        cyc();
        #1;
        chk("sb_cnt1", 64'(busy_cnt), 64'd1);
        chk("sb_busy_r4", 64'(rd_busy), 64'b01);
        iss_addr = 5'd9;
        cyc();
        #1;
        chk("sb_cnt2", 64'(busy_cnt), 64'd2);
        iss_addr = 5'd4;
        cyc();
        idle();
        #1;
        chk("sb_cnt2_again", 64'(busy_cnt), 64'd2);
        chk("sb_busy_both", 64'(rd_busy), 64'b11);
        wr1_en = 1'b1; wr1_addr = 5'd4; wr1_data = 32'h44;
        #1;
        chk("sb_wr_clr_busy", 64'(rd_busy), 64'b10);
        chk("sb_wr_clr_data", 64'(rd_data[31:0]), 64'h44);
        cyc();
        idle();
        #1;
        chk("sb_cnt_after_wr", 64'(busy_cnt), 64'd1);
        iss_en = 1'b1; iss_addr = 5'd9;
        wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h99;
        #1;
        chk("sb_isswr_busy", 64'(rd_busy), 64'b00);
        chk("sb_isswr_data", 64'(rd_data[63:32]), 64'h99);
        cyc();
        idle();
        #1;
        chk("sb_isswr_cnt", 64'(busy_cnt), 64'd1);
        chk("sb_isswr_pend", 64'(rd_busy), 64'b10);

        // ---------------- mid-operation reset ----------------
        iss_en = 1'b1; iss_addr = 5'd10;
        cyc();
        iss_addr = 5'd11;
        cyc();
        idle();
        #1;
        chk("mid_cnt3", 64'(busy_cnt), 64'd3);
        wr0_en = 1'b1; wr0_addr = 5'd12; wr0_data = 32'hABCD;
        setRd(5'd12, 5'd3);
        #1;
        chk("mid_bypass", 64'(rd_data[31:0]), 64'hABCD);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cnt", 64'(busy_cnt), 64'd0);
        chk("mid_rst_rd", 64'(rd_data), 64'd0);
        cyc();
        chk("mid_rst_hold", 64'(rd_data), 64'd0);
        idle();
        rst_n = 1'b1;
        #1;
        chk("mid_post_rd", 64'(rd_data), 64'd0);
        chk("mid_post_cnt", 64'(busy_cnt), 64'd0);
        setRd(5'd9, 5'd7);
        #1;
        chk("mid_post_busy", 64'(rd_busy), 64'd0);
        chk("mid_post_r7", 64'(rd_data[63:32]), 64'd0);
        cyc();
        chk("mid_post_cnt2", 64'(busy_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule : tb_reg_file_sb
`default_nettype wire

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the single-write processor register file.
- Provides NUM_RD combinational read ports, two write ports (ALU writeback and load writeback), same-cycle write-to-read bypass, and an optional hardwired zero register.
- Contains a per-register pending scoreboard: the issue stage marks a destination busy, and writeback clears it.
- Sits between decode/issue and writeback in the pipelined core, and feeds hazard detection.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of architectural registers (>=2).
- ADDR_W, 5, register index width; must equal $clog2(NUM_REGS).
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never marked pending.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- rd_addr  in  NUM_RD*ADDR_W  read indices; port k occupies bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, packed the same way.
- rd_busy  out  NUM_RD  per-port flag: source still pending after this cycle's writebacks.
- wr0_en  in  1  write port 0 enable (ALU writeback).
- wr0_addr  in  ADDR_W  write port 0 index.
- wr0_data  in  DATA_W  write port 0 data.
- wr1_en  in  1  write port 1 enable (load writeback).
- wr1_addr  in  ADDR_W  write port 1 index.
- wr1_data  in  DATA_W  write port 1 data.
- iss_en  in  1  issue: mark destination pending.
- iss_addr  in  ADDR_W  destination index being issued.
- busy_cnt  out  ADDR_W+1  registered count of pending registers.

Behaviour:
- Reset (rst_n low, async):
  - All registers cleared to 0 and all pending bits cleared.
  - busy_cnt = 0.
  - While in reset, rd_data = 0 and rd_busy = 0.
  - Writes and issues are ignored until the first clk edge after rst_n rises.
  - Reset asserted mid-operation discards all in-flight state; no partial write survives.
- Storage writes: at posedge clk, an enabled port writes its addr.
  - Both ports enabled to the same addr: wr1 wins.
  - Different addrs: both written in the same cycle.
- Reads: combinational, with bypass priority wr1 match > wr0 match > stored value.
  - A match requires the write's en=1 and addr == rd_addr.
  - Read-during-write therefore returns the new data in the same cycle (write-through).
- Zero register (ZERO_REG=1):
  - Index 0 always reads 0 with rd_busy=0.
  - Writes to index 0 are dropped and never bypassed.
  - iss_addr=0 is ignored.
- Scoreboard: pending[r] is updated at posedge clk.
  - Set when iss_en && iss_addr==r.
  - Cleared when (wr0_en && wr0_addr==r) || (wr1_en && wr1_addr==r).
  - Issue and write to the same r in one cycle: set wins, because the new producer supersedes the old one.
  - Issue to an already-pending r: stays 1, no counting.
- rd_busy[k] = pending[rd_addr_k] AND NOT (any write matching rd_addr_k this cycle).
  - The iss of the current cycle does not affect rd_busy until the next cycle.
- busy_cnt: a popcount of the next-state pending vector, registered, so it equals the count of pending bits after the edge.
  - Range 0..NUM_REGS (NUM_REGS-1 when ZERO_REG=1); never wraps.
- Latency:
  - Write to stored-read: 1 cycle (0 cycles via bypass).
  - Issue to rd_busy: 1 cycle.
  - Write to rd_busy clear: 0 cycles.
- Out-of-range indices (NUM_REGS not a power of 2, addr >= NUM_REGS):
  - Writes and issues dropped.
  - Reads return 0, rd_busy = 0.

Decomposition:
- Shared package reg_file_pkg:
  - Default constants RF_DATA_W=32, RF_NUM_REGS=32, RF_ADDR_W=5.
  - A function for the ceil-log2 width check.
- Sub-module reg_file_sb_rdport: one instance per read port, generated NUM_RD times.
  - Contains the bypass mux, the zero/range check, and the rd_busy logic.
- Storage, pending vector and popcount stay in the top.

Test Plan:
1. Reset then read: rst_n=0 with registers previously written, release, read r5 and r31 -> rd_data=0, rd_busy=0, busy_cnt=0.
2. Write then read: wr0 r3=0xDEADBEEF at cycle n, read r3 in cycle n -> 0xDEADBEEF via bypass; read in n+1 -> 0xDEADBEEF from storage.
3. Dual write, same addr: wr0 r7=0x11, wr1 r7=0x22 in one cycle -> bypass and next-cycle read give 0x22.
4. Zero register: wr0 r0=0xFFFFFFFF and iss r0 -> read r0 = 0, rd_busy=0, busy_cnt unchanged.
5. Scoreboard: iss r4, r9, r4 over three cycles -> busy_cnt 1,2,2.
   - wr1 r4 -> rd_busy on r4 drops in the same cycle, busy_cnt=1 next cycle.
   - Simultaneous iss r9 + wr0 r9 -> r9 stays pending, busy_cnt=1.
6. Mid-operation reset: with 3 regs pending and wr0 active, assert rst_n low between edges -> busy_cnt=0 and rd_data=0 immediately; after release, the previously written data is gone.
